// File: rtl/npu_host_pkg.sv
// Shared types for the NPU host sequencer: command opcodes, FSM states, status bit index.
package npu_host_pkg;
  typedef enum logic [1:0] {
    WR_SINGLE = 2'd0,
    WR_BURST  = 2'd1,
    RD_SINGLE = 2'd2,
    POLL      = 2'd3
  } cmd_op_e;

  typedef enum logic [2:0] {
    IDLE,
    WR1,
    BURST,
    RD,
    POLL_RD,
    POLL_GAP_ST,
    RSP
  } host_state_e;

  localparam int unsigned OP_END_BIT = 0;
endpackage

// File: rtl/pkg_memorymap.sv
// NPU memory-map window base addresses shared by the host model and the NPU controller.
package pkg_memorymap;
  localparam logic [31:0] NPU_PARA_Start = 32'h4000_0000;
  localparam logic [31:0] NPU_IMEM_Start = 32'h4001_0000;
  localparam logic [31:0] NPU_WMEM_Start = 32'h4002_0000;
  localparam logic [31:0] NPU_BMEM_Start = 32'h4003_0000;
  localparam logic [31:0] NPU_OMEM_Start = 32'h4004_0000;
endpackage

// File: rtl/npu_host_sequencer_if.sv
// Command, burst-source, bus and response signals between host model, sequencer and NPU slave.
interface npu_host_sequencer_if #(
  parameter int unsigned DWidth     = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
);
  import npu_host_pkg::*;

  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  cmd_op_e               cmd_op_i;
  logic [ADDR_WIDTH-1:0] cmd_addr_i;
  logic [DWidth-1:0]     cmd_data_i;
  logic [LEN_WIDTH-1:0]  cmd_len_i;
  logic                  src_valid_i;
  logic                  src_ready_o;
  logic [DWidth-1:0]     src_data_i;
  logic                  cen_o;
  logic                  wen_o;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic [DWidth-1:0]     wdata_o;
  logic [DWidth-1:0]     rdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DWidth-1:0]     rsp_data_o;
  logic                  rsp_err_o;

  // master: the sequencer itself; slave: host model plus memory-mapped NPU port
  modport master (
    input  cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_len_i,
    input  src_valid_i, src_data_i, rdata_i, rsp_ready_i,
    output cmd_ready_o, src_ready_o, cen_o, wen_o, addr_o, wdata_o,
    output rsp_valid_o, rsp_data_o, rsp_err_o
  );

  modport slave (
    output cmd_valid_i, cmd_op_i, cmd_addr_i, cmd_data_i, cmd_len_i,
    output src_valid_i, src_data_i, rdata_i, rsp_ready_i,
    input  cmd_ready_o, src_ready_o, cen_o, wen_o, addr_o, wdata_o,
    input  rsp_valid_o, rsp_data_o, rsp_err_o
  );
endinterface

// File: rtl/npu_host_addr_gen.sv
// Burst address generator: word-aligned base, word index counter, wrapped byte address, last flag.
module npu_host_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic [ADDR_WIDTH-1:0] addr_c,
  output logic                  last_c
);
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;

  always_comb begin
    base_d = base_q;
    len_d  = len_q;
    idx_d  = idx_q;
    if (load_i) begin
      base_d = base_i & ~ADDR_WIDTH'(3);
      len_d  = len_i;
      idx_d  = '0;
    end else if (adv_i) begin
      idx_d = idx_q + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      base_q <= '0;
      len_q  <= '0;
      idx_q  <= '0;
    end else begin
      base_q <= base_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
    end
  end

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  assign addr_c = base_q + (ADDR_WIDTH'(idx_q) << 2);
  assign last_c = ((LEN_WIDTH+1)'(idx_q) + (LEN_WIDTH+1)'(1)) == (LEN_WIDTH+1)'(len_q);
endmodule

// File: rtl/npu_host_sequencer.sv
// Host-side bus master: turns write/burst/read/poll commands into single-cycle cen/wen beats.
module npu_host_sequencer
  import npu_host_pkg::*;
#(
  parameter int unsigned DWidth     = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned POLL_GAP   = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  npu_host_sequencer_if.master bus,
  output logic                 busy_o
);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  host_state_e           state_q, state_d;
  logic                  cen_q, cen_d, wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DWidth-1:0]     wdata_q, wdata_d;
  logic [DWidth-1:0]     rsp_data_q, rsp_data_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d, to_next;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  timed_out;
  logic                  gen_load, gen_adv, gen_last;
  logic [ADDR_WIDTH-1:0] gen_addr, cmd_word_addr;

  npu_host_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_addr_gen (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .load_i (gen_load),
    .adv_i  (gen_adv),
    .base_i (bus.cmd_addr_i),
    .len_i  (bus.cmd_len_i),
    .addr_c (gen_addr),
    .last_c (gen_last)
  );

  assign cmd_word_addr = bus.cmd_addr_i & ~ADDR_WIDTH'(3);
  assign to_next       = to_cnt_q + TO_W'(1);
  assign timed_out     = (to_next == TO_W'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    cen_d      = 1'b0;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    to_cnt_d   = to_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    gen_load   = 1'b0;
    gen_adv    = 1'b0;
    unique case (state_q)
      // Single-beat commands launch their beat on the accepting edge.
      IDLE: begin
        if (bus.cmd_valid_i) begin
          gen_load   = 1'b1;
          to_cnt_d   = '0;
          gap_cnt_d  = '0;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
          unique case (bus.cmd_op_i)
            WR_SINGLE: begin
              cen_d   = 1'b1;
              wen_d   = 1'b1;
              addr_d  = cmd_word_addr;
              wdata_d = bus.cmd_data_i;
              state_d = WR1;
            end
            WR_BURST:  state_d = (bus.cmd_len_i == '0) ? RSP : BURST;
            RD_SINGLE: begin
              cen_d   = 1'b1;
              addr_d  = cmd_word_addr;
              state_d = RD;
            end
            POLL: begin
              cen_d   = 1'b1;
              addr_d  = cmd_word_addr;
              state_d = POLL_RD;
            end
          endcase
        end
      end
      WR1: state_d = RSP;
      BURST: begin
        if (bus.src_valid_i) begin
          cen_d   = 1'b1;
          wen_d   = 1'b1;
          addr_d  = gen_addr;
          wdata_d = bus.src_data_i;
          gen_adv = 1'b1;
          if (gen_last) state_d = RSP;
        end
      end
      RD: begin
        rsp_data_d = bus.rdata_i;
        state_d    = RSP;
      end
      // A successful sample takes priority over a coincident timeout.
      POLL_RD: begin
        to_cnt_d   = to_next;
        rsp_data_d = bus.rdata_i;
        if (bus.rdata_i[OP_END_BIT]) begin
          state_d = RSP;
        end else if (timed_out) begin
          rsp_err_d = 1'b1;
          state_d   = RSP;
        end else if (POLL_GAP == 0) begin
          cen_d  = 1'b1;
          addr_d = gen_addr;
        end else begin
          gap_cnt_d = '0;
          state_d   = POLL_GAP_ST;
        end
      end
      POLL_GAP_ST: begin
        to_cnt_d = to_next;
        if (timed_out) begin
          rsp_err_d = 1'b1;
          state_d   = RSP;
        end else if (gap_cnt_q == GAP_W'(POLL_GAP - 1)) begin
          cen_d   = 1'b1;
          addr_d  = gen_addr;
          state_d = POLL_RD;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      RSP: if (bus.rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cen_q      <= 1'b0;
      wen_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      to_cnt_q   <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cen_q      <= cen_d;
      wen_q      <= wen_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      to_cnt_q   <= to_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign bus.cmd_ready_o = rst_ni && (state_q == IDLE);
  assign bus.src_ready_o = rst_ni && (state_q == BURST);
  assign bus.cen_o       = cen_q;
  assign bus.wen_o       = wen_q;
  assign bus.addr_o      = addr_q;
  assign bus.wdata_o     = wdata_q;
  assign bus.rsp_valid_o = (state_q == RSP);
  assign bus.rsp_data_o  = rsp_data_q;
  assign bus.rsp_err_o   = rsp_err_q;
  assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_npu_host_sequencer.sv
// Bench for npu_host_sequencer: directed and randomized commands against a cycle-level reference.
module tb_npu_host_sequencer;
  import npu_host_pkg::*;
  import pkg_memorymap::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 32;
  localparam int unsigned LW  = 16;
  localparam int unsigned GAP = 4;
  localparam int unsigned TMO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  npu_host_sequencer_if #(.DWidth(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

  npu_host_sequencer #(
    .DWidth(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .POLL_GAP(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus),
    .busy_o (busy)
  );

  task automatic idle_inputs();
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i    = WR_SINGLE;
    bus.cmd_addr_i  = '0;
    bus.cmd_data_i  = '0;
    bus.cmd_len_i   = '0;
    bus.src_valid_i = 1'b0;
    bus.src_data_i  = '0;
    bus.rdata_i     = '0;
    bus.rsp_ready_i = 1'b0;
  endtask

  // Offer one command; returns at the negedge of the cycle after the handshake.
  task automatic issue(input cmd_op_e op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [LW-1:0] l);
    int w = 0;
    while (bus.cmd_ready_o !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (bus.cmd_ready_o !== 1'b1) begin
      bad++;
      $display("FAIL cmd_ready: got %b want 1", bus.cmd_ready_o);
    end
    bus.cmd_valid_i = 1'b1;
    bus.cmd_op_i    = op;
    bus.cmd_addr_i  = a;
    bus.cmd_data_i  = d;
    bus.cmd_len_i   = l;
    @(negedge clk);
    bus.cmd_valid_i = 1'b0;
    bus.cmd_addr_i  = $urandom;
    bus.cmd_data_i  = $urandom;
  endtask

  // Called at the negedge of the first cycle in which a response is required.
  task automatic rsp_phase(input string nm, input logic [DW-1:0] ed, input logic ee, input int hold);
    for (int i = 0; i <= hold; i++) begin
      total++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== ed || bus.rsp_err_o !== ee ||
          bus.cmd_ready_o !== 1'b0 || (i > 0 && bus.cen_o !== 1'b0)) begin
        bad++;
        $display("FAIL %s_rsp[%0d]: got valid=%b data=%h err=%b ready=%b cen=%b want valid=1 data=%h err=%b ready=0",
                 nm, i, bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_err_o, bus.cmd_ready_o, bus.cen_o, ed, ee);
      end
      bus.rsp_ready_i = (i == hold);
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b0;
    total++;
    if (bus.rsp_valid_o !== 1'b0 || busy !== 1'b0 || bus.cmd_ready_o !== 1'b1 || bus.cen_o !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: got valid=%b busy=%b ready=%b cen=%b want 0 0 1 0",
               nm, bus.rsp_valid_o, busy, bus.cmd_ready_o, bus.cen_o);
    end
  endtask

  task automatic run_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    logic [AW-1:0] ea;
    ea = a & ~AW'(3);
    issue(WR_SINGLE, a, d, '0);
    total++;
    if (bus.cen_o !== 1'b1 || bus.wen_o !== 1'b1 || bus.addr_o !== ea || bus.wdata_o !== d ||
        bus.rsp_valid_o !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL wr_beat: got cen=%b wen=%b addr=%h wdata=%h rv=%b busy=%b want 1 1 %h %h 0 1",
               bus.cen_o, bus.wen_o, bus.addr_o, bus.wdata_o, bus.rsp_valid_o, busy, ea, d);
    end
    @(negedge clk);
    total++;
    if (bus.cen_o !== 1'b0 || bus.wen_o !== 1'b0 || bus.addr_o !== ea || bus.wdata_o !== d) begin
      bad++;
      $display("FAIL wr_after: got cen=%b wen=%b addr=%h wdata=%h want 0 0 %h %h",
               bus.cen_o, bus.wen_o, bus.addr_o, bus.wdata_o, ea, d);
    end
    rsp_phase("wr", '0, 1'b0, hold);
  endtask

  task automatic run_rd(input logic [AW-1:0] a, input logic [DW-1:0] rd, input int hold);
    logic [AW-1:0] ea;
    ea = a & ~AW'(3);
    issue(RD_SINGLE, a, $urandom, '0);
    total++;
    if (bus.cen_o !== 1'b1 || bus.wen_o !== 1'b0 || bus.addr_o !== ea || bus.rsp_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL rd_beat: got cen=%b wen=%b addr=%h rv=%b want 1 0 %h 0",
               bus.cen_o, bus.wen_o, bus.addr_o, bus.rsp_valid_o, ea);
    end
    bus.rdata_i = rd;
    @(negedge clk);
    bus.rdata_i = $urandom;
    rsp_phase("rd", rd, 1'b0, hold);
  endtask

  // Burst: src_valid random with probability vprob%, optional single bubble, optional reset.
  task automatic run_burst(input logic [AW-1:0] base, input int len, input int vprob,
                           input int bubble_after, input int hold, input int rst_after);
    logic [AW-1:0] eb, ea;
    logic [DW-1:0] last_w = '0;
    logic          hs_prev = 1'b0;
    logic          bubbled = 1'b0;
    int            n = 0;
    eb = base & ~AW'(3);
    issue(WR_BURST, base, $urandom, LW'(len));
    for (int c = 0; c < 4 * len + 20; c++) begin
      ea = eb + AW'(4 * (n - 1));
      total++;
      if (bus.cen_o !== hs_prev ||
          (hs_prev && (bus.wen_o !== 1'b1 || bus.addr_o !== ea || bus.wdata_o !== last_w))) begin
        bad++;
        $display("FAIL burst_beat[%0d]: got cen=%b wen=%b addr=%h wdata=%h want cen=%b addr=%h wdata=%h",
                 n, bus.cen_o, bus.wen_o, bus.addr_o, bus.wdata_o, hs_prev, ea, last_w);
      end
      if (n == len) break;
      total++;
      if (bus.rsp_valid_o !== 1'b0 || bus.src_ready_o !== 1'b1) begin
        bad++;
        $display("FAIL burst_flow[%0d]: got rv=%b src_ready=%b want 0 1", n, bus.rsp_valid_o, bus.src_ready_o);
      end
      if (rst_after > 0 && n == rst_after && hs_prev) begin
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if (bus.cen_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || busy !== 1'b0 ||
            bus.cmd_ready_o !== 1'b0 || bus.src_ready_o !== 1'b0 || bus.wen_o !== 1'b0) begin
          bad++;
          $display("FAIL burst_rst: got cen=%b wen=%b rv=%b busy=%b ready=%b src_ready=%b want all 0",
                   bus.cen_o, bus.wen_o, bus.rsp_valid_o, busy, bus.cmd_ready_o, bus.src_ready_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          total++;
          if (bus.cen_o !== 1'b0 || bus.rsp_valid_o !== 1'b0 || bus.cmd_ready_o !== 1'b1 ||
              bus.src_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL burst_post_rst[%0d]: got cen=%b rv=%b ready=%b src_ready=%b want 0 0 1 0",
                     k, bus.cen_o, bus.rsp_valid_o, bus.cmd_ready_o, bus.src_ready_o);
          end
        end
        bus.src_valid_i = 1'b0;
        return;
      end
      bus.src_valid_i = ($urandom_range(99) < vprob) || (c > 2 * len + 5);
      if (bubble_after >= 0 && n == bubble_after && !bubbled) begin
        bus.src_valid_i = 1'b0;
        bubbled = 1'b1;
      end
      bus.src_data_i = $urandom;
      hs_prev = bus.src_valid_i;
      if (hs_prev) begin
        last_w = bus.src_data_i;
        n++;
      end
      @(negedge clk);
    end
    bus.src_valid_i = 1'b0;
    total++;
    if (n != len) begin
      bad++;
      $display("FAIL burst_count: got %0d want %0d", n, len);
    end
    rsp_phase("burst", '0, 1'b0, hold);
  endtask

  // Poll: read number succ_k (0-based) returns op_end; -1 never succeeds.
  task automatic run_poll(input logic [AW-1:0] a, input int succ_k, input bit exact, input int hold);
    logic [AW-1:0] ea;
    logic [DW-1:0] last_rd = '0;
    int            c_succ, fin, reads = 0, exp_reads;
    bit            success, exp_rd;
    ea      = a & ~AW'(3);
    c_succ  = (succ_k >= 0) ? 1 + int'(GAP + 1) * succ_k : 1 << 30;
    success = (c_succ <= int'(TMO));
    fin     = success ? c_succ : int'(TMO);
    exp_reads = (fin - 1) / int'(GAP + 1) + 1;
    issue(POLL, a, $urandom, '0);
    for (int c = 1; c <= fin; c++) begin
      exp_rd = ((c - 1) % int'(GAP + 1)) == 0;
      total++;
      if (bus.cen_o !== exp_rd || (exp_rd && (bus.wen_o !== 1'b0 || bus.addr_o !== ea)) ||
          bus.rsp_valid_o !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL poll_cyc[%0d]: got cen=%b wen=%b addr=%h rv=%b busy=%b want cen=%b addr=%h rv=0 busy=1",
                 c, bus.cen_o, bus.wen_o, bus.addr_o, bus.rsp_valid_o, busy, exp_rd, ea);
      end
      if (bus.cen_o === 1'b1 && bus.wen_o === 1'b0) begin
        if (reads == succ_k) bus.rdata_i = exact ? DW'(1) : ($urandom | DW'(1));
        else                 bus.rdata_i = exact ? DW'(0) : ($urandom & ~DW'(1));
        last_rd = bus.rdata_i;
        reads++;
      end else begin
        bus.rdata_i = $urandom;
      end
      @(negedge clk);
    end
    bus.rdata_i = '0;
    total++;
    if (reads != exp_reads || bus.cen_o !== 1'b0) begin
      bad++;
      $display("FAIL poll_reads: got reads=%0d cen=%b want reads=%0d cen=0", reads, bus.cen_o, exp_reads);
    end
    rsp_phase("poll", last_rd, !success, hold);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.cen_o !== 1'b0 || bus.wen_o !== 1'b0 || bus.addr_o !== '0 || bus.wdata_o !== '0 ||
        bus.rsp_valid_o !== 1'b0 || bus.rsp_data_o !== '0 || bus.rsp_err_o !== 1'b0 ||
        bus.src_ready_o !== 1'b0 || busy !== 1'b0 || bus.cmd_ready_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_vals: got cen=%b wen=%b addr=%h wdata=%h rv=%b rd=%h err=%b src_rdy=%b busy=%b rdy=%b want all 0",
               bus.cen_o, bus.wen_o, bus.addr_o, bus.wdata_o, bus.rsp_valid_o, bus.rsp_data_o,
               bus.rsp_err_o, bus.src_ready_o, busy, bus.cmd_ready_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.cmd_ready_o !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got ready=%b busy=%b want 1 0", bus.cmd_ready_o, busy);
    end
  endtask

  task automatic test_wr_single();
    run_wr(NPU_PARA_Start + 32'h24, 32'h10, 0);
    run_wr($urandom, $urandom, 2);
  endtask

  task automatic test_burst();
    run_burst(NPU_IMEM_Start, 4, 100, 2, 0, 0);
    run_burst(NPU_WMEM_Start + 32'h3, 6, 60, -1, 1, 0);
    run_burst(32'hFFFF_FFF4, 5, 80, -1, 0, 0);
  endtask

  task automatic test_burst_len0();
    run_burst(NPU_BMEM_Start, 0, 100, -1, 0, 0);
  endtask

  task automatic test_poll();
    run_poll(NPU_PARA_Start + 32'h4, 2, 1'b1, 0);
  endtask

  task automatic test_poll_timeout();
    run_poll(NPU_PARA_Start + 32'h4, -1, 1'b1, 1);
  endtask

  task automatic test_rd_single();
    run_rd(NPU_OMEM_Start + 32'h8, 32'h5, 3);
  endtask

  task automatic test_reset_mid_burst();
    run_burst(NPU_IMEM_Start, 8, 100, -1, 0, 3);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(3))
        0: run_wr($urandom, $urandom, int'($urandom_range(3)));
        1: run_burst(($urandom_range(3) == 0) ? 32'hFFFF_FFF8 : $urandom,
                     int'($urandom_range(6)), 70, -1, int'($urandom_range(3)), 0);
        2: run_rd($urandom, $urandom, int'($urandom_range(3)));
        default: run_poll($urandom, int'($urandom_range(5)) - 1, 1'b0, int'($urandom_range(3)));
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_wr_single();
    test_burst();
    test_burst_len0();
    test_poll();
    test_poll_timeout();
    test_rd_single();
    test_reset_mid_burst();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
